// File: rtl/irda_pkg.sv
// Shared types and frame constants for the IrDA SIR transmit path.
package irda_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = 7;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Frame as shifted out LSB first: start, data[0..6], parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [DATA_BITS-1:0] data_v,
        input logic                 parity_v
    );
        return {STOP_BIT, parity_v, data_v, START_BIT};
    endfunction

endpackage

// File: rtl/irda_bit_timer.sv
// Bit-period timer: cycle counter, end-of-bit strobe, and pulse-window flag
// for the cycle that follows the current clock edge.
module irda_bit_timer
    import irda_pkg::*;
#(
    parameter int BIT_CYCLES   = 16,
    parameter int PULSE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_end,
    output logic in_pulse_nxt
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CW-1:0] cyc_cnt_r;
    logic [CW-1:0] cyc_nxt_s;

    assign bit_end = run && (cyc_cnt_r == CW'(BIT_CYCLES - 1));

    // Next cycle count: counts only while sending, restarts on every bit boundary.
    always_comb begin
        cyc_nxt_s = {CW{1'b0}};
        if (!run) begin
            cyc_nxt_s = {CW{1'b0}};
        end else if (bit_end) begin
            cyc_nxt_s = {CW{1'b0}};
        end else begin
            cyc_nxt_s = cyc_cnt_r + CW'(1);
        end
    end

    // Pulse window evaluated on the upcoming count so the encoder can register it aligned.
    always_comb begin
        in_pulse_nxt = 1'b0;
        if (cyc_nxt_s < CW'(PULSE_CYCLES)) begin
            in_pulse_nxt = 1'b1;
        end else begin
            in_pulse_nxt = 1'b0;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_r <= {CW{1'b0}};
        end else begin
            cyc_cnt_r <= cyc_nxt_s;
        end
    end

endmodule

// File: rtl/irda_tx_serializer.sv
// IrDA SIR transmit serializer: 10-bit frame, return-to-zero pulse per 0 bit.
// Optional macro IRDA_TX_NRZ_EN adds the unencoded nrz_tx debug output.
module irda_tx_serializer
    import irda_pkg::*;
#(
    parameter int BIT_CYCLES   = 16,
    parameter int PULSE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] data,
    input  logic       parity_bit,
    input  logic       tx_valid,
    output logic       tx_ready,
`ifdef IRDA_TX_NRZ_EN
    output logic       nrz_tx,
`endif
    output logic       tx_done,
    output logic       ir_tx
);

    tx_state_e             state_r, state_nxt_s;
    logic [3:0]            bit_cnt_r, bit_cnt_nxt_s;
    logic [FRAME_BITS-1:0] shift_r, shift_nxt_s;
    logic                  done_nxt_s;
    logic                  ir_nxt_s;
    logic                  ir_tx_r;
    logic                  tx_done_r;
    logic                  bit_end_s;
    logic                  in_pulse_nxt_s;
    logic                  sending_s;

    assign sending_s = (state_r == SEND);
    assign tx_ready  = (state_r == IDLE);
    assign ir_tx     = ir_tx_r;
    assign tx_done   = tx_done_r;

    irda_bit_timer #(
        .BIT_CYCLES   (BIT_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_bit_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (sending_s),
        .bit_end      (bit_end_s),
        .in_pulse_nxt (in_pulse_nxt_s)
    );

    // Frame FSM: load on acceptance, shift on each bit boundary, finish after the stop bit.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        done_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt_s   = SEND;
                    bit_cnt_nxt_s = 4'd0;
                    shift_nxt_s   = build_frame(data, parity_bit);
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            SEND: begin
                if (bit_end_s && (bit_cnt_r == 4'(FRAME_BITS - 1))) begin
                    state_nxt_s   = IDLE;
                    bit_cnt_nxt_s = 4'd0;
                    shift_nxt_s   = {FRAME_BITS{1'b0}};
                    done_nxt_s    = 1'b1;
                end else if (bit_end_s) begin
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    shift_nxt_s   = {1'b0, shift_r[FRAME_BITS-1:1]};
                end else begin
                    state_nxt_s   = SEND;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                bit_cnt_nxt_s = 4'd0;
                shift_nxt_s   = {FRAME_BITS{1'b0}};
            end
        endcase
    end

    // Encoder works on next-cycle values so the registered pulse lines up with the frame bit.
    always_comb begin
        ir_nxt_s = 1'b0;
        if ((state_nxt_s == SEND) && (shift_nxt_s[0] == 1'b0) && in_pulse_nxt_s) begin
            ir_nxt_s = 1'b1;
        end else begin
            ir_nxt_s = 1'b0;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= {FRAME_BITS{1'b0}};
            ir_tx_r   <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            ir_tx_r   <= ir_nxt_s;
            tx_done_r <= done_nxt_s;
        end
    end

`ifdef IRDA_TX_NRZ_EN
    logic nrz_tx_r;
    assign nrz_tx = nrz_tx_r;

    // Raw frame level, idling at the mark level between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrz_tx_r <= 1'b1;
        end else if (state_nxt_s == SEND) begin
            nrz_tx_r <= shift_nxt_s[0];
        end else begin
            nrz_tx_r <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/irda_tx_serializer.md
# irda_tx_serializer

Transmit-side IrDA SIR frame serializer. Accepts one 7-bit character plus its externally generated odd-parity bit (from `ParityGenerator`) over a valid/ready handshake. Serializes the character as a 10-bit frame: start, 7 data bits LSB first, parity, stop. Each bit is encoded as an IrDA return-to-zero pulse on `ir_tx`, which drives the IR LED driver.

## Interface
- `BIT_CYCLES`, default 16: clock cycles per bit period; legal range ≥ 2.
- `PULSE_CYCLES`, default 3: width of the IR pulse for a 0 bit, in clock cycles; legal range 1 ≤ PULSE_CYCLES < BIT_CYCLES.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `data`, in, 7: character to send; sampled only on acceptance.
- `parity_bit`, in, 1: odd-parity bit for `data`; sampled only on acceptance.
- `tx_valid`, in, 1: `data` and `parity_bit` are valid.
- `tx_ready`, out, 1: block can accept a character.
- `tx_done`, out, 1: one-cycle pulse when a frame completes.
- `ir_tx`, out, 1: encoded IR output; active-high pulse.

## Operation
- **States:** IDLE and SEND.
- **Acceptance:** a character is accepted on a rising edge where `tx_valid && tx_ready`.
  - On acceptance, the 10-bit frame {1, `parity_bit`, `data`, 0} is loaded into the shift register. It is sent LSB first.
  - The state moves IDLE→SEND, `bit_cnt`=0 and `cyc_cnt`=0.
- **tx_ready:** equals `state==IDLE`. It is combinational from the state register.
- **SEND, per cycle:** `cyc_cnt` increments.
  - When `cyc_cnt==BIT_CYCLES-1`: `cyc_cnt` wraps to 0, the shift register shifts right, and `bit_cnt` increments.
  - At the end of bit 9: the state moves to IDLE.
- **Encoding:** registered output. `ir_tx`=1 when the current frame bit is 0 and `cyc_cnt` < PULSE_CYCLES; otherwise `ir_tx`=0.
  - A 1 bit produces no pulse.
  - The stop bit always produces no pulse.
- **tx_done:** registered. High for exactly the first IDLE cycle after a frame.
- **Input stability:** `data` and `parity_bit` are ignored outside acceptance. Changes during SEND have no effect.
- **Parity:** the block does not check or compute parity; it transmits `parity_bit` as given.
- **Reset (asynchronous), including mid-frame:**
  - State=IDLE, counters=0, shift register=0.
  - `ir_tx`=0, `tx_done`=0, `tx_ready`=1.
  - No acceptance occurs while `rst_n` is low.
  - After release, the next frame starts clean with no residue from the aborted frame.

## Timing
- Acceptance at edge k: the start-bit pulse occupies cycles k+1 … k+PULSE_CYCLES.
- Frame occupies cycles k+1 … k+10·BIT_CYCLES.
- Cycle k+10·BIT_CYCLES+1: IDLE, `tx_done`=1, `tx_ready`=1.
- Minimum frame-to-frame period: 10·BIT_CYCLES+1 cycles, which is 161 with defaults.
- Bit n pulse, when the bit is 0: cycles k+1+n·BIT_CYCLES … k+n·BIT_CYCLES+PULSE_CYCLES.
- Counter widths: `cyc_cnt` is $clog2(BIT_CYCLES) bits; `bit_cnt` is 4 bits.

## Configuration
- Macro: `IRDA_TX_NRZ_EN`.
- **Defined:** an extra output `nrz_tx` (out, 1) is present.
  - It carries the unencoded frame bit level, registered with the same latency as `ir_tx`.
  - Idle/reset value is 1.
  - Used for UART-mode debug.
- **Undefined:** the port and its logic are absent. `ir_tx` behaviour is identical in both builds.

## Structure
- **Package `irda_pkg`:**
  - State enum {IDLE, SEND}.
  - FRAME_BITS=10.
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - DATA_BITS=7.
- **Sub-module `irda_bit_timer`:** `cyc_cnt` plus the end-of-bit strobe and the `in_pulse` flag (`cyc_cnt` < PULSE_CYCLES). The frame FSM and shift register stay in the top module.

## Test plan
- **Reset:** assert `rst_n`=0 → `ir_tx`=0, `tx_done`=0, `tx_ready`=1. `tx_valid`=1 during reset → no frame sent.
- **All-zero data:** `data`=7'h00, `parity_bit`=1, accepted at edge k → 3-cycle pulses in bits 0–7 at k+1+16n, n=0..7; no pulse in bits 8 and 9. `tx_done` at k+161.
- **All-one data:** `data`=7'h7F, `parity_bit`=0 → pulses only in bit 0 (start) and bit 8 (parity).
- **Alternating data:** `data`=7'h55, `parity_bit`=1 → pulses only in bits 0, 2, 4, 6. With `IRDA_TX_NRZ_EN`, `nrz_tx` sequence is 0,1,0,1,0,1,0,1,1,1.
- **Back-to-back:** `tx_valid` held high with `data` changed mid-frame → first frame unaffected; second start pulse begins exactly 161 cycles after the first; `tx_ready` low throughout SEND.
- **Reset mid-frame:** `rst_n` pulsed low during bit 4 → `ir_tx` falls immediately; `tx_ready`=1 after release; the next accepted 7'h55 frame matches the alternating-data pattern exactly.
